event_scheduler: RTL and testbench

EVENT_SCHEDULER -- requirements
Module: event_scheduler

---
 rtl/event_scheduler_pkg.sv | 11 +
 rtl/chan_fall_detect.sv | 40 ++++
 rtl/event_scheduler.sv | 117 +++++++++++
 tb/tb_event_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/event_scheduler_pkg.sv
// Shared definitions for the event scheduler: falling-edge detector state encoding.
package event_scheduler_pkg;

   // Detector states: line idle high, first low sample (one-cycle tick), held low.
   typedef enum logic [1:0] {
      DET_HIGH = 2'b00,
      DET_EDGE = 2'b01,
      DET_LOW  = 2'b10
   } det_state_t;

endpackage

// File: rtl/chan_fall_detect.sv
// Per-channel falling-edge detector. The tick is high for exactly one cycle
// (the EDGE state) per high-to-low transition of an active-low event line.
module chan_fall_detect
   import event_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic tick
);

   det_state_t r_state;
   det_state_t w_state_next;

   // State register; reset parks the detector in HIGH so a line held low
   // through reset release still yields one event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= DET_HIGH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and tick decode; unknown encodings recover to HIGH.
   always_comb begin
      w_state_next = DET_HIGH;
      tick         = 1'b0;
      case (r_state)
         DET_HIGH: w_state_next = level ? DET_HIGH : DET_EDGE;
         DET_EDGE: begin
            tick         = 1'b1;
            w_state_next = level ? DET_HIGH : DET_LOW;
         end
         DET_LOW:  w_state_next = level ? DET_HIGH : DET_LOW;
         default:  w_state_next = DET_HIGH;
      endcase
   end

endmodule

// File: rtl/event_scheduler.sv
// Event scheduler: NCH active-low event channels, one pending flag per channel,
// sticky overflow flags for lost events, and a round-robin grant to a shared
// service resource. A grant is held stable until accepted (grant_valid & srv_ready).
module event_scheduler
   import event_scheduler_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IDW = $clog2(NCH)
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] level,
   input  logic           srv_ready,
   input  logic           ovf_clr,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic [NCH-1:0] pend,
   output logic [NCH-1:0] overflow
);

   logic [NCH-1:0] r_pend;
   logic [NCH-1:0] r_ovf;
   logic [IDW-1:0] r_ptr;
   logic           r_gnt_valid;
   logic [IDW-1:0] r_gnt_id;

   logic [NCH-1:0] w_tick;
   logic [NCH-1:0] w_acc;
   logic [NCH-1:0] w_pend_next;
   logic [NCH-1:0] w_ovf_next;
   logic           w_accept;
   logic           w_pick_found;
   logic [IDW-1:0] w_pick_id;
   logic [IDW:0]   w_scan_sum;
   logic [IDW-1:0] w_scan_idx;
   logic [IDW-1:0] w_ptr_next;

   assign w_accept = r_gnt_valid & srv_ready;

   // Per-channel detector plus pending/overflow next-state. A tick on the
   // channel being accepted re-arms pend instead of counting as lost.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      chan_fall_detect u_det (
         .clk   (clk),
         .rst   (rst),
         .level (level[gi]),
         .tick  (w_tick[gi])
      );

      assign w_acc[gi]       = w_accept & (r_gnt_id == IDW'(gi));
      assign w_pend_next[gi] = w_tick[gi] | (r_pend[gi] & ~w_acc[gi]);
      // Overflow set wins over a same-cycle clear.
      assign w_ovf_next[gi]  = (w_tick[gi] & r_pend[gi] & ~w_acc[gi])
                             | (r_ovf[gi] & ~ovf_clr);
   end

   // Round-robin pick: first pending channel at or after ptr, wrapping to 0.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_id    = '0;
      w_scan_sum   = '0;
      w_scan_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         w_scan_sum = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_scan_sum >= (IDW+1)'(NCH)) begin
            w_scan_sum = w_scan_sum - (IDW+1)'(NCH);
         end
         w_scan_idx = w_scan_sum[IDW-1:0];
         if (!w_pick_found && r_pend[w_scan_idx]) begin
            w_pick_found = 1'b1;
            w_pick_id    = w_scan_idx;
         end
      end
   end

   // Pointer advances to the channel after the one just served.
   always_comb begin
      w_ptr_next = '0;
      if (r_gnt_id != IDW'(NCH-1)) begin
         w_ptr_next = r_gnt_id + IDW'(1);
      end
   end

   // Pending and overflow flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
         r_ovf  <= '0;
      end else begin
         r_pend <= w_pend_next;
         r_ovf  <= w_ovf_next;
      end
   end

   // Grant register: issue when idle and something is pending, hold until
   // accept, then drop for one cycle so the next pick sees updated flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_ptr       <= '0;
      end else if (w_accept) begin
         r_gnt_valid <= 1'b0;
         r_ptr       <= w_ptr_next;
      end else if (!r_gnt_valid && w_pick_found) begin
         r_gnt_valid <= 1'b1;
         r_gnt_id    <= w_pick_id;
      end
   end

   assign grant_valid = r_gnt_valid;
   assign grant_id    = r_gnt_id;
   assign pend        = r_pend;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_event_scheduler.sv
// Directed bench for event_scheduler: expected grant ids are queued as
// stimulus is driven and checked when the DUT accepts a grant.
module tb_event_scheduler;

   localparam int NCH = 4;
   localparam int IDW = 2;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] level;
   logic           srv_ready;
   logic           ovf_clr;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic [NCH-1:0] pend;
   logic [NCH-1:0] overflow;

   int checks;
   int failures;
   int exp_q[$];
   int exp_id;

   event_scheduler #(.NCH(NCH), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .level       (level),
      .srv_ready   (srv_ready),
      .ovf_clr     (ovf_clr),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .pend        (pend),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: an accept happens at the next rising edge whenever
   // grant_valid and srv_ready are both high mid-cycle.
   always @(negedge clk) begin
      if (rst && grant_valid && srv_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL grant_unexpected obs=%0d exp=none", grant_id);
         end else begin
            exp_id = exp_q.pop_front();
            assert (int'(grant_id) === exp_id) else begin
               failures++;
               $error("FAIL grant_order obs=%0d exp=%0d", grant_id, exp_id);
            end
            $display("accept grant_id=%0d expected=%0d", grant_id, exp_id);
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      level     = '1;
      srv_ready = 1'b0;
      ovf_clr   = 1'b0;
      rst       = 1'b0;

      // Reset state
      repeat (3) tick_clk();
      chk("rst_gv",   32'(grant_valid), 32'h0);
      chk("rst_gid",  32'(grant_id),    32'h0);
      chk("rst_pend", 32'(pend),        32'h0);
      chk("rst_ovf",  32'(overflow),    32'h0);
      rst = 1'b1;
      repeat (2) tick_clk();

      // All channels fall together, ptr=0: grants 0,1,2,3
      srv_ready = 1'b1;
      level     = 4'b0000;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
      tick_clk();
      tick_clk();
      chk("all_pend",  32'(pend), 32'hF);
      chk("all_gv_lo", 32'(grant_valid), 32'h0);
      tick_clk();
      chk("all_gv",  32'(grant_valid), 32'h1);
      chk("all_gid", 32'(grant_id),    32'h0);
      repeat (7) tick_clk();
      chk("all_pend_clr", 32'(pend), 32'h0);
      chk("all_gv_end",   32'(grant_valid), 32'h0);
      chk("all_q_empty",  32'(exp_q.size()), 32'h0);
      level = '1;
      repeat (2) tick_clk();

      // ptr wrapped to 0: channels 0 and 3 together serve 0 first
      level = 4'b0110;
      exp_q.push_back(0); exp_q.push_back(3);
      repeat (6) tick_clk();
      chk("wrap_pend",    32'(pend), 32'h0);
      chk("wrap_q_empty", 32'(exp_q.size()), 32'h0);
      level = '1;
      repeat (2) tick_clk();

      // Single event on channel 2, latency check
      level[2] = 1'b0;
      exp_q.push_back(2);
      tick_clk();
      tick_clk();
      chk("c2_pend",  32'(pend), 32'h4);
      chk("c2_gv_lo", 32'(grant_valid), 32'h0);
      tick_clk();
      chk("c2_gv",  32'(grant_valid), 32'h1);
      chk("c2_gid", 32'(grant_id),    32'h2);
      tick_clk();
      chk("c2_pend_clr", 32'(pend), 32'h0);
      chk("c2_gv_drop",  32'(grant_valid), 32'h0);
      level = '1;
      repeat (2) tick_clk();

      // Overflow on channel 1 while pending and stalled
      srv_ready = 1'b0;
      level[1]  = 1'b0;
      exp_q.push_back(1);
      repeat (3) tick_clk();
      level[1] = 1'b1;
      repeat (2) tick_clk();
      level[1] = 1'b0;
      repeat (2) tick_clk();
      chk("ovf_set",  32'(overflow), 32'h2);
      chk("ovf_pend", 32'(pend),     32'h2);
      chk("ovf_gid",  32'(grant_id), 32'h1);
      srv_ready = 1'b1;
      tick_clk();
      srv_ready = 1'b0;
      chk("ovf_gv_drop", 32'(grant_valid), 32'h0);
      chk("ovf_pend_clr", 32'(pend), 32'h0);
      chk("ovf_sticky",  32'(overflow), 32'h2);
      repeat (3) tick_clk();
      chk("ovf_one_grant", 32'(grant_valid), 32'h0);
      level = '1;
      ovf_clr = 1'b1;
      tick_clk();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'h0);

      // Channel 3 ticks in the same cycle it is accepted
      level[3] = 1'b0;
      exp_q.push_back(3);
      repeat (3) tick_clk();
      chk("same_gid1", 32'(grant_id), 32'h3);
      level[3] = 1'b1;
      repeat (2) tick_clk();
      level[3] = 1'b0;
      tick_clk();
      srv_ready = 1'b1;
      exp_q.push_back(3);
      tick_clk();
      chk("same_pend",  32'(pend), 32'h8);
      chk("same_gv_lo", 32'(grant_valid), 32'h0);
      chk("same_ovf",   32'(overflow), 32'h0);
      tick_clk();
      chk("same_gv2",  32'(grant_valid), 32'h1);
      chk("same_gid2", 32'(grant_id), 32'h3);
      tick_clk();
      chk("same_pend_clr", 32'(pend), 32'h0);
      srv_ready = 1'b0;
      level = '1;
      repeat (2) tick_clk();

      // Grant on channel 0 held through a 10-cycle stall while channel 2 ticks
      level[0] = 1'b0;
      exp_q.push_back(0);
      repeat (3) tick_clk();
      level[2] = 1'b0;
      exp_q.push_back(2);
      for (int c = 0; c < 10; c++) begin
         tick_clk();
         chk("stall_gv",  32'(grant_valid), 32'h1);
         chk("stall_gid", 32'(grant_id),    32'h0);
      end
      chk("stall_pend", 32'(pend), 32'h5);
      srv_ready = 1'b1;
      tick_clk();
      chk("stall_gv_drop", 32'(grant_valid), 32'h0);
      tick_clk();
      chk("stall_gid2", 32'(grant_id), 32'h2);
      tick_clk();
      srv_ready = 1'b0;
      chk("stall_pend_clr", 32'(pend), 32'h0);
      level = '1;
      repeat (2) tick_clk();

      // Reset mid-grant, line held low through release
      level[1] = 1'b0;
      repeat (3) tick_clk();
      chk("mid_gv", 32'(grant_valid), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_gv",   32'(grant_valid), 32'h0);
      chk("async_gid",  32'(grant_id),    32'h0);
      chk("async_pend", 32'(pend),        32'h0);
      chk("async_ovf",  32'(overflow),    32'h0);
      repeat (2) tick_clk();
      srv_ready = 1'b1;
      exp_q.push_back(1);
      rst = 1'b1;
      repeat (8) tick_clk();
      chk("rel_pend",    32'(pend), 32'h0);
      chk("rel_gv",      32'(grant_valid), 32'h0);
      chk("rel_q_empty", 32'(exp_q.size()), 32'h0);
      level = '1;
      srv_ready = 1'b0;
      tick_clk();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
